otter_mem_arbiter: RTL and testbench
====================================

OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MMIO, default 2, extra wait cycles (0..15) for addresses >= MMIO_BASE.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports f_req in 1, f_addr in 32, f_rdata out 32, f_ack out 1  instruction-fetch requester (read-only, word).
REQ-005 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_size in 2, d_rdata out 32, d_ack out 1, d_err out 1  data requester.
REQ-006 SHALL have ports m_en out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_size out 2, m_rdata in 32  single shared memory/MMIO port.

Function
REQ-007 SHALL use states IDLE, ISSUE, WAIT, DONE.
REQ-008 IDLE with any req SHALL latch grant, addr, we, wdata and size into registers, then go to ISSUE; with no req, SHALL stay in IDLE.
REQ-009 Fetch requests SHALL latch we=0 and size=2'b10.
REQ-010 Contention in IDLE (f_req and d_req both high) SHALL go to the requester favoured by the round-robin pointer.
REQ-011 After each grant, the pointer SHALL favour the other requester.
REQ-012 A single requester SHALL be granted regardless of pointer state.
REQ-013 ISSUE SHALL drive m_en=1 for exactly one cycle, with m_we, m_addr, m_wdata and m_size taken from the latched values.
REQ-014 From ISSUE, a latched addr >= MMIO_BASE with WAIT_MMIO>0 SHALL go to WAIT with counter=WAIT_MMIO; otherwise SHALL go to DONE.
REQ-015 WAIT SHALL decrement the counter each cycle and SHALL go to DONE in the cycle after the counter reaches 1.
REQ-016 DONE SHALL pulse the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-017 During DONE, the granted requester's rdata SHALL equal m_rdata (the memory holds m_rdata until its next m_en); outside DONE, f_rdata/d_rdata are don't-care.
REQ-018 Latency from a req sampled in IDLE to ack SHALL be 2 cycles for the memory region and 2+WAIT_MMIO cycles for the MMIO region.
REQ-019 Requesters SHALL hold req and payload stable until ack; req deasserts the cycle after ack, and a req still high in IDLE SHALL be treated as a new request.
REQ-020 Misaligned data access (size 2'b10 with addr[1:0]!=0, or size 2'b01 with addr[0]!=0) SHALL skip ISSUE and WAIT, go directly IDLE->DONE with d_ack=1 and d_err=1, and SHALL NOT assert m_en.
REQ-021 d_err SHALL be 0 in all other cycles; fetch never flags an error.
REQ-022 m_en, m_we and both acks SHALL be 0 in every state other than those specified above.
REQ-023 Arbitration SHALL never pre-empt a transaction in flight; one transaction at a time.

Reset
REQ-024 RST high SHALL force state=IDLE, pointer favouring data, counter=0, and m_en=m_we=f_ack=d_ack=d_err=0 from the next edge.
REQ-025 RST high mid-transaction SHALL abandon the transaction without issuing an ack.
REQ-026 Latched address/data registers SHALL reset to 0.

Structure
REQ-027 Package otter_mem_pkg SHALL hold the state enum, MMIO_BASE=32'h1100_0000, and the size encoding (00 byte, 01 half, 10 word).
REQ-028 Two-way round-robin selection SHALL be a sub-module otter_rr_arb2 (inputs req[1:0], advance; output grant[1:0]; pointer internal).

Verification
REQ-029 Fetch only, f_addr=0x0000_0040, m_rdata=0x0000_0013 -> m_en in cycle 1, f_ack in cycle 2 with f_rdata=0x0000_0013.
REQ-030 Simultaneous f_req/d_req held after reset -> data granted first; fetch is granted on the next IDLE; a third contention goes to data again.
REQ-031 d_we=1, d_addr=0x1100_0004, d_wdata=0xA5, WAIT_MMIO=2 -> m_en=m_we=1 once, d_ack at cycle 4, no second m_en.
REQ-032 d_size=2'b10, d_addr=0x0000_0102 -> d_ack=d_err=1 at cycle 1, m_en never asserted.
REQ-033 RST raised during WAIT -> no ack, state IDLE, all outputs 0 next cycle; a fresh f_req then completes normally in 2 cycles.
REQ-034 WAIT_MMIO=0, MMIO read -> ack at cycle 2, WAIT never entered.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory arbiter.
package otter_mem_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Access size encoding on d_size / m_size.
  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  // Addresses at or above this base hit the slower MMIO region.
  localparam logic [31:0] MMIO_BASE = 32'h1100_0000;

  // Word accesses need addr[1:0]==0 and half accesses need addr[0]==0.
  // Byte accesses and the unused 2'b11 encoding are never flagged.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] addr);
    logic mis;
    mis = 1'b0;
    if ((size == SizeWord) && (addr[1:0] != 2'b00)) mis = 1'b1;
    if ((size == SizeHalf) && addr[0]) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/otter_rr_arb2.sv
// Two-way round-robin selector. Bit 0 is the fetch port, bit 1 the data port.
// After every grant the pointer swings to the requester that was not served.
module otter_rr_arb2 (
  input  logic       clk,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic favour_data_q;

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = favour_data_q ? 2'b10 : 2'b01;
    end
  end

  // Move the pointer away from whoever was just granted.
  always_ff @(posedge clk) begin
    if (RST) begin
      favour_data_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      favour_data_q <= grant[0];
    end
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one shared
// memory/MMIO port, one transaction at a time. All handshake outputs are
// registered; the address/data outputs come straight from the latch regs.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int unsigned WAIT_MMIO = 2
) (
  input  logic        clk,
  input  logic        RST,
  // instruction fetch (word reads only)
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_ack,
  // data
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  // shared memory port
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_MMIO);

  state_e      state_q;
  logic        gnt_data_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [3:0]  cnt_q;
  logic        m_en_q;
  logic        m_we_q;
  logic        f_ack_q;
  logic        d_ack_q;
  logic        d_err_q;

  logic [1:0]  req_vec;
  logic [1:0]  grant;
  logic        advance;

  assign req_vec = {d_req, f_req};
  assign advance = (state_q == StIdle);

  otter_rr_arb2 u_rr_arb (
    .clk     (clk),
    .RST     (RST),
    .req     (req_vec),
    .advance (advance),
    .grant   (grant)
  );

  // Memory holds m_rdata until its next m_en, so a straight pass-through is
  // valid throughout DONE; outside DONE these are don't-care.
  assign f_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_size  = size_q;
  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;

  // Transaction sequencer: latch in IDLE, strobe in ISSUE, stall in WAIT,
  // acknowledge in DONE. Pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      cnt_q      <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      f_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      m_en_q  <= 1'b0;
      m_we_q  <= 1'b0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant[1]) begin
            gnt_data_q <= 1'b1;
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
            we_q       <= d_we;
            size_q     <= d_size;
            if (is_misaligned(d_size, d_addr)) begin
              // Reject without touching the memory port.
              state_q <= StDone;
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
            end else begin
              state_q <= StIssue;
              m_en_q  <= 1'b1;
              m_we_q  <= d_we;
            end
          end else if (grant[0]) begin
            gnt_data_q <= 1'b0;
            addr_q     <= f_addr;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= SizeWord;
            state_q    <= StIssue;
            m_en_q     <= 1'b1;
          end
        end

        StIssue: begin
          if ((addr_q >= MMIO_BASE) && (WaitCnt != 4'd0)) begin
            state_q <= StWait;
            cnt_q   <= WaitCnt;
          end else begin
            state_q <= StDone;
            f_ack_q <= ~gnt_data_q;
            d_ack_q <= gnt_data_q;
          end
        end

        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= StDone;
            f_ack_q <= ~gnt_data_q;
            d_ack_q <= gnt_data_q;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // we_q is kept as part of the latched transaction record; m_we is its
  // one-cycle qualified copy.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: directed scenarios followed by
// randomized two-requester traffic checked against a transaction-level model.
module tb_otter_mem_arbiter;

  localparam int unsigned WAIT = 2;
  localparam logic [31:0] MMIO = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        RST;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
  logic        f_ack, d_ack, d_err, m_en, m_we;
  logic [1:0]  m_size;

  // second instance with no MMIO wait states
  logic        f_req0, d_req0;
  logic [31:0] f_rdata0, d_rdata0, m_addr0, m_wdata0;
  logic        f_ack0, d_ack0, d_err0, m_en0, m_we0;
  logic [1:0]  m_size0;

  int checks = 0;
  int errors = 0;
  bit favour_data;

  always #5 clk = ~clk;

  otter_mem_arbiter #(.WAIT_MMIO(WAIT)) dut (
    .clk(clk), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_rdata(m_rdata)
  );

  otter_mem_arbiter #(.WAIT_MMIO(0)) dut0 (
    .clk(clk), .RST(RST),
    .f_req(f_req0), .f_addr(f_addr), .f_rdata(f_rdata0), .f_ack(f_ack0),
    .d_req(d_req0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata0), .d_ack(d_ack0), .d_err(d_err0),
    .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_size(m_size0),
    .m_rdata(m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input string fld, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %b expected %b", name, fld, obs, exp);
    end
  endtask

  task automatic chk32(input string name, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", name, fld, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 1) == 1) a = MMIO + 32'($urandom_range(0, 255));
    else a = $urandom & 32'h00FF_FFFF;
    return a;
  endfunction

  // Runs one transaction from IDLE with the currently held requests and
  // checks every cycle until the arbiter is back in IDLE.
  task automatic do_txn(input string name, input logic [31:0] rd);
    bit win_d, mis;
    int lat;
    logic [31:0] a;
    logic [1:0] sz;
    logic we;
    win_d = (f_req && d_req) ? favour_data : d_req;
    favour_data = !win_d;
    if (win_d) begin
      a = d_addr; sz = d_size; we = d_we; mis = misaligned(d_size, d_addr);
    end else begin
      a = f_addr; sz = 2'b10; we = 1'b0; mis = 1'b0;
    end
    if (mis) lat = 1;
    else if (a >= MMIO && WAIT > 0) lat = 2 + int'(WAIT);
    else lat = 2;
    m_rdata = rd;
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk1(name, "m_en", m_en, k == 1 && !mis);
      if (k == 1 && !mis) begin
        chk1(name, "m_we", m_we, we);
        chk32(name, "m_addr", m_addr, a);
        chk32(name, "m_size", 32'(m_size), 32'(sz));
        if (win_d) chk32(name, "m_wdata", m_wdata, d_wdata);
      end else begin
        chk1(name, "m_we_idle", m_we, 1'b0);
      end
      chk1(name, "f_ack", f_ack, !win_d && k == lat);
      chk1(name, "d_ack", d_ack, win_d && k == lat);
      chk1(name, "d_err", d_err, mis && k == lat);
      if (k == lat && !mis) chk32(name, "rdata", win_d ? d_rdata : f_rdata, rd);
    end
    tick();
    chk1(name, "idle_m_en", m_en, 1'b0);
    chk1(name, "idle_f_ack", f_ack, 1'b0);
    chk1(name, "idle_d_ack", d_ack, 1'b0);
    chk1(name, "idle_d_err", d_err, 1'b0);
    if (win_d) d_req = 1'b0;
    else f_req = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    f_req = 1'b0; d_req = 1'b0; f_req0 = 1'b0; d_req0 = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    favour_data = 1'b1;
  endtask

  initial begin
    f_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_size = 2'b10; m_rdata = '0;
    do_reset();

    // reset state
    chk1("reset", "m_en", m_en, 1'b0);
    chk1("reset", "m_we", m_we, 1'b0);
    chk1("reset", "f_ack", f_ack, 1'b0);
    chk1("reset", "d_ack", d_ack, 1'b0);
    chk1("reset", "d_err", d_err, 1'b0);
    chk32("reset", "m_addr", m_addr, 32'h0);
    chk32("reset", "m_wdata", m_wdata, 32'h0);

    // plain fetch
    f_addr = 32'h0000_0040; f_req = 1'b1;
    do_txn("fetch", 32'h0000_0013);

    // contention after reset: data, fetch, data
    do_reset();
    f_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0; d_size = 2'b10;
    f_req = 1'b1; d_req = 1'b1;
    do_txn("cont1", 32'h1111_0001);
    do_txn("cont2", 32'h2222_0002);
    f_req = 1'b1; d_req = 1'b1;
    do_txn("cont3", 32'h3333_0003);
    f_req = 1'b1;
    do_txn("cont4", 32'h4444_0004);

    // MMIO write with wait states
    d_we = 1'b1; d_addr = 32'h1100_0004; d_wdata = 32'h0000_00A5; d_size = 2'b10; d_req = 1'b1;
    do_txn("mmio_wr", 32'h0);
    chk1("mmio_wr", "no_second_m_en", m_en, 1'b0);

    // misaligned word access
    d_we = 1'b0; d_addr = 32'h0000_0102; d_size = 2'b10; d_req = 1'b1;
    do_txn("misalign", 32'hDEAD_BEEF);

    // reset in the middle of a WAIT
    d_addr = 32'h1100_0010; d_size = 2'b10; d_we = 1'b1; d_req = 1'b1;
    tick();
    chk1("rst_mid", "issue_m_en", m_en, 1'b1);
    tick();
    chk1("rst_mid", "wait_m_en", m_en, 1'b0);
    chk1("rst_mid", "wait_d_ack", d_ack, 1'b0);
    RST = 1'b1;
    tick();
    chk1("rst_mid", "m_en", m_en, 1'b0);
    chk1("rst_mid", "m_we", m_we, 1'b0);
    chk1("rst_mid", "d_ack", d_ack, 1'b0);
    chk1("rst_mid", "f_ack", f_ack, 1'b0);
    chk1("rst_mid", "d_err", d_err, 1'b0);
    RST = 1'b0; d_req = 1'b0; d_we = 1'b0; favour_data = 1'b1;
    tick();
    chk1("rst_mid", "after_d_ack", d_ack, 1'b0);
    f_addr = 32'h0000_0080; f_req = 1'b1;
    do_txn("post_rst", 32'h0BAD_F00D);

    // zero-wait MMIO read on the second instance
    d_addr = 32'h1100_0020; d_we = 1'b0; d_size = 2'b10; m_rdata = 32'hCAFE_0034;
    d_req0 = 1'b1;
    tick();
    chk1("nowait", "m_en", m_en0, 1'b1);
    chk1("nowait", "d_ack_early", d_ack0, 1'b0);
    tick();
    chk1("nowait", "d_ack", d_ack0, 1'b1);
    chk1("nowait", "m_en_off", m_en0, 1'b0);
    chk32("nowait", "d_rdata", d_rdata0, 32'hCAFE_0034);
    tick();
    chk1("nowait", "ack_pulse", d_ack0, 1'b0);
    d_req0 = 1'b0;

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin
        f_req = 1'b1;
        f_addr = rand_addr();
      end
      if (!d_req && ($urandom_range(0, 1) == 1 || !f_req)) begin
        d_req = 1'b1;
        d_addr = rand_addr();
        d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_size = 2'($urandom_range(0, 2));
      end
      do_txn("rnd", $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
